// File: rtl/dmem_access_unit.sv
// Data block-RAM initiator: turns MEM-stage byte/half/word loads and stores into
// byte-enable RAM accesses. Optional misalignment trapping via `DMEM_ALIGN_CHECK_EN.
module dmem_access_unit #(
    parameter int RAM_ADDR_W  = 32,
    parameter int RAM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic                  ram_en,
    output logic [3:0]            ram_we,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [1:0] WAIT_LAST = 2'(RAM_LATENCY - 1);

    state_t                  state_reg, state_next;
    logic                    is_store_reg;
    logic [1:0]              size_reg;
    logic                    signed_reg;
    logic [1:0]              lane_reg;
    logic                    err_reg;
    logic [1:0]              wait_cnt_reg;
    logic                    ram_en_reg;
    logic [3:0]              ram_we_reg;
    logic [RAM_ADDR_W-1:0]   ram_addr_reg;
    logic [31:0]             ram_wdata_reg;
    logic [31:0]             resp_rdata_reg;
    logic                    resp_err_reg;

    logic                    misaligned;
    logic [3:0]              lane_mask;
    logic [31:0]             wdata_rep;
    logic [RAM_ADDR_W-1:0]   word_idx;
    logic [31:0]             load_ext;
    logic [7:0]              byte_sel;
    logic [15:0]             half_sel;

`ifdef DMEM_ALIGN_CHECK_EN
    always_comb begin
        case (req_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = req_addr[0];
            default: misaligned = |req_addr[1:0];
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

    generate
        if (RAM_ADDR_W <= 30) begin : g_addr_trunc
            assign word_idx = req_addr[RAM_ADDR_W+1:2];
        end else begin : g_addr_zext
            assign word_idx = RAM_ADDR_W'(req_addr[31:2]);
        end
    endgenerate

    // Lane mask and replicated write data; half/word ignore the low bits they do not select on.
    always_comb begin
        lane_mask = 4'b1111;
        wdata_rep = req_wdata;
        case (req_size)
            2'b00: begin
                lane_mask = 4'b0001 << req_addr[1:0];
                wdata_rep = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                lane_mask = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        byte_sel = ram_rdata[{lane_reg, 3'b000} +: 8];
        half_sel = lane_reg[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        case (size_reg)
            2'b00:   load_ext = {{24{signed_reg & byte_sel[7]}}, byte_sel};
            2'b01:   load_ext = {{16{signed_reg & half_sel[15]}}, half_sel};
            default: load_ext = ram_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req_valid) state_next = ISSUE;
            ISSUE:   state_next = (err_reg || is_store_reg) ? RESP : WAIT;
            WAIT:    if (wait_cnt_reg == WAIT_LAST) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_store_reg   <= 1'b0;
            size_reg       <= 2'b00;
            signed_reg     <= 1'b0;
            lane_reg       <= 2'b00;
            err_reg        <= 1'b0;
            wait_cnt_reg   <= 2'b00;
            ram_en_reg     <= 1'b0;
            ram_we_reg     <= 4'b0000;
            ram_addr_reg   <= '0;
            ram_wdata_reg  <= 32'h0;
            resp_rdata_reg <= 32'h0;
            resp_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: if (req_valid) begin
                    is_store_reg  <= req_we;
                    size_reg      <= req_size;
                    signed_reg    <= req_signed;
                    lane_reg      <= req_addr[1:0];
                    err_reg       <= misaligned;
                    ram_en_reg    <= !misaligned;
                    ram_we_reg    <= (req_we && !misaligned) ? lane_mask : 4'b0000;
                    ram_addr_reg  <= word_idx;
                    ram_wdata_reg <= wdata_rep;
                end
                ISSUE: begin
                    ram_en_reg   <= 1'b0;
                    ram_we_reg   <= 4'b0000;
                    wait_cnt_reg <= 2'b00;
                    if (err_reg || is_store_reg) begin
                        resp_rdata_reg <= 32'h0;
                        resp_err_reg   <= err_reg;
                    end
                end
                WAIT: begin
                    wait_cnt_reg <= wait_cnt_reg + 2'd1;
                    if (wait_cnt_reg == WAIT_LAST) begin
                        resp_rdata_reg <= load_ext;
                        resp_err_reg   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready  = (state_reg == IDLE);
    assign resp_valid = (state_reg == RESP);
    assign resp_rdata = resp_rdata_reg;
    assign resp_err   = resp_err_reg;
    assign ram_en     = ram_en_reg;
    assign ram_we     = ram_we_reg;
    assign ram_addr   = ram_addr_reg;
    assign ram_wdata  = ram_wdata_reg;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit with a small behavioural block-RAM model.
// Expectations follow `DMEM_ALIGN_CHECK_EN when it is defined.
module tb_dmem_access_unit;

    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    dmem_access_unit #(.RAM_ADDR_W(32), .RAM_LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // Block RAM model: registered read, optional extra output stage.
    logic [31:0] mem [0:63];
    logic [31:0] rd_pipe [0:1];

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        rd_pipe[0] = 32'h0;
        rd_pipe[1] = 32'h0;
    end

    always @(posedge clk) begin
        if (ram_en) begin
            for (int i = 0; i < 4; i++)
                if (ram_we[i]) mem[ram_addr[5:0]][8*i +: 8] <= ram_wdata[8*i +: 8];
            rd_pipe[0] <= mem[ram_addr[5:0]];
        end
        rd_pipe[1] <= rd_pipe[0];
    end

    assign ram_rdata = rd_pipe[LAT-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Called at a negedge with the unit idle; returns at a negedge with the unit idle again.
    task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                          input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] exp_we, input logic [31:0] exp_wdata,
                          input logic [31:0] exp_rdata, input logic exp_err);
        int n;
        bit got;
        int exp_lat;
        exp_lat = (exp_err || we) ? 2 : LAT + 2;
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        @(posedge clk);
        n = 0;
        got = 1'b0;
        while (!got && n < 8) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                req_valid = 1'b0;
                check({tag, "_en"}, 32'(ram_en), exp_err ? 32'd0 : 32'd1);
                check({tag, "_we"}, 32'(ram_we), 32'(exp_we));
                if (!exp_err) check({tag, "_addr"}, ram_addr, {2'b00, addr[31:2]});
                if (we) check({tag, "_wdata"}, ram_wdata, exp_wdata);
            end else begin
                check({tag, "_en_off"}, 32'(ram_en), 32'd0);
            end
            check({tag, "_busy"}, 32'(req_ready), 32'd0);
            if (resp_valid) got = 1'b1;
        end
        check({tag, "_lat"}, got ? n : 99, exp_lat);
        check({tag, "_rdata"}, resp_rdata, exp_rdata);
        check({tag, "_err"}, 32'(resp_err), 32'(exp_err));
        @(negedge clk);
        check({tag, "_pulse"}, 32'(resp_valid), 32'd0);
        $display("txn %s we=%0d size=%0d addr=0x%08h rdata=0x%08h err=%0d lat=%0d",
                 tag, we, size, addr, resp_rdata, resp_err, n);
    endtask

    logic [31:0] b2b_data [0:2];
    bit          acc_now;
    bit          prev_en;
    int          idx, acc_cnt, en_cnt, dbl_cnt, resp_cnt, resp_seen;

    initial begin
        b2b_data[0] = 32'hA1A2A3A4;
        b2b_data[1] = 32'hB1B2B3B4;
        b2b_data[2] = 32'hC1C2C3C4;

        #1;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_ram_en", 32'(ram_en), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_req("sb0", 1, 2'b00, 0, 32'h0, 32'h44, 4'b0001, 32'h44444444, 32'h0, 0);
        do_req("sb1", 1, 2'b00, 0, 32'h1, 32'h33, 4'b0010, 32'h33333333, 32'h0, 0);
        do_req("sh2", 1, 2'b01, 0, 32'h2, 32'h1122, 4'b1100, 32'h11221122, 32'h0, 0);
        do_req("lw0", 0, 2'b10, 0, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h11223344, 0);
        do_req("sw4", 1, 2'b10, 0, 32'h4, 32'h80FF7F01, 4'b1111, 32'h80FF7F01, 32'h0, 0);
        do_req("lb7", 0, 2'b00, 1, 32'h7, 32'h0, 4'b0000, 32'h0, 32'hFFFFFF80, 0);
        do_req("lbu7", 0, 2'b00, 0, 32'h7, 32'h0, 4'b0000, 32'h0, 32'h00000080, 0);
        do_req("lb5", 0, 2'b00, 1, 32'h5, 32'h0, 4'b0000, 32'h0, 32'h0000007F, 0);
        do_req("lh4", 0, 2'b01, 1, 32'h4, 32'h0, 4'b0000, 32'h0, 32'h00007F01, 0);
        do_req("lh6", 0, 2'b01, 1, 32'h6, 32'h0, 4'b0000, 32'h0, 32'hFFFF80FF, 0);
        do_req("lhu6", 0, 2'b01, 0, 32'h6, 32'h0, 4'b0000, 32'h0, 32'h000080FF, 0);
`ifdef DMEM_ALIGN_CHECK_EN
        do_req("lw2", 0, 2'b10, 0, 32'h2, 32'h0, 4'b0000, 32'h0, 32'h0, 1);
        do_req("lw0b", 0, 2'b10, 0, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h11223344, 0);
`else
        do_req("lw2", 0, 2'b10, 0, 32'h2, 32'h0, 4'b0000, 32'h0, 32'h11223344, 0);
`endif

        // Three stores queued behind a permanently asserted req_valid.
        idx = 0; acc_cnt = 0; en_cnt = 0; dbl_cnt = 0; resp_cnt = 0; prev_en = 1'b0;
        req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 32'h10; req_wdata = b2b_data[0];
        req_valid = 1'b1;
        for (int c = 0; c < 40 && resp_cnt < 3; c++) begin
            acc_now = req_valid && req_ready;
            if (acc_now) acc_cnt++;
            @(negedge clk);
            if (acc_now) begin
                idx++;
                if (idx < 3) begin
                    req_addr = 32'h10 + 32'(4 * idx);
                    req_wdata = b2b_data[idx];
                end else begin
                    req_valid = 1'b0;
                end
            end
            if (ram_en) begin
                en_cnt++;
                if (prev_en) dbl_cnt++;
            end
            prev_en = ram_en;
            if (resp_valid) resp_cnt++;
        end
        req_valid = 1'b0;
        check("b2b_accepts", 32'(acc_cnt), 32'd3);
        check("b2b_en_cycles", 32'(en_cnt), 32'd3);
        check("b2b_en_double", 32'(dbl_cnt), 32'd0);
        check("b2b_resps", 32'(resp_cnt), 32'd3);
        $display("txn b2b accepts=%0d en=%0d resps=%0d", acc_cnt, en_cnt, resp_cnt);
        @(negedge clk);
        do_req("lw10", 0, 2'b10, 0, 32'h10, 32'h0, 4'b0000, 32'h0, 32'hA1A2A3A4, 0);
        do_req("lw14", 0, 2'b10, 0, 32'h14, 32'h0, 4'b0000, 32'h0, 32'hB1B2B3B4, 0);
        do_req("lw18", 0, 2'b10, 0, 32'h18, 32'h0, 4'b0000, 32'h0, 32'hC1C2C3C4, 0);

        // Reset asserted while a load sits in WAIT.
        req_we = 1'b0; req_size = 2'b10; req_addr = 32'h4; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("arst_ready", 32'(req_ready), 32'd1);
        check("arst_resp_valid", 32'(resp_valid), 32'd0);
        check("arst_rdata", resp_rdata, 32'h0);
        check("arst_err", 32'(resp_err), 32'd0);
        check("arst_ram_en", 32'(ram_en), 32'd0);
        check("arst_ram_we", 32'(ram_we), 32'd0);
        check("arst_ram_addr", ram_addr, 32'h0);
        check("arst_ram_wdata", ram_wdata, 32'h0);
        resp_seen = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid) resp_seen++;
        end
        check("arst_no_resp", 32'(resp_seen), 32'd0);
        $display("txn reset_in_wait stray_resps=%0d", resp_seen);
        do_req("sw8", 1, 2'b10, 0, 32'h8, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 32'h0, 0);
        do_req("lw8", 0, 2'b10, 0, 32'h8, 32'h0, 4'b0000, 32'h0, 32'hDEADBEEF, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
